// File: rtl/add_serial_nbit.sv
// add_serial_nbit: digit-serial WIDTH-bit adder/subtractor, DIGIT bits per clock
// ports: clk, reset (sync, active-high), start/A/B/cIn/sub sampled when idle,
//        out/cOut hold last result, busy while running, done pulses on completion
// ADD_SERIAL_FLAGS_EN adds ovf (signed overflow) and zero (out==0) outputs
module add_serial_nbit #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cIn,
   input  logic             sub,
   output logic [WIDTH-1:0] out,
   output logic             cOut,
   output logic             busy,
   output logic             done
`ifdef ADD_SERIAL_FLAGS_EN
   ,
   output logic             ovf,
   output logic             zero
`endif
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_n;
   logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_n;
   logic [DIGIT-1:0] s;
   logic [DIGIT:0]   c;
   logic [CW-1:0]    cnt;
   logic             carry, last;
   if (WIDTH % DIGIT != 0) begin : g_chk
      $error("WIDTH must be a multiple of DIGIT");
   end
   assign c[0] = carry;
   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      assign s[i]   = a_sr[i] ^ b_sr[i] ^ c[i];
      assign c[i+1] = (a_sr[i] & b_sr[i]) | (c[i] & (a_sr[i] ^ b_sr[i]));
   end
   // sum digit enters at the MSB end; after N digits the result is aligned
   assign res_n = WIDTH'({s, res_sr} >> DIGIT);
   assign last  = cnt == CW'(N - 1);
   always_comb begin
      state_n = (state == IDLE) ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
   end
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         out    <= '0;
         cOut   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
`ifdef ADD_SERIAL_FLAGS_EN
         ovf    <= 1'b0;
         zero   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         if (state == IDLE && start) begin
            a_sr  <= A;
            b_sr  <= B ^ {WIDTH{sub}};
            carry <= cIn ^ sub;
            cnt   <= '0;
            busy  <= 1'b1;
         end else if (state == RUN) begin
            a_sr   <= a_sr >> DIGIT;
            b_sr   <= b_sr >> DIGIT;
            res_sr <= res_n;
            carry  <= c[DIGIT];
            cnt    <= cnt + CW'(1);
            if (last) begin
               out  <= res_n;
               cOut <= c[DIGIT];
               done <= 1'b1;
               busy <= 1'b0;
`ifdef ADD_SERIAL_FLAGS_EN
               ovf  <= c[DIGIT] ^ c[DIGIT-1];
               zero <= res_n == '0;
`endif
            end
         end
      end
   end
endmodule

// File: tb/tb_add_serial_nbit.sv
// tb_add_serial_nbit: directed checks of add_serial_nbit (8/2 and 32/32 configs)
module tb_add_serial_nbit;
   logic        clk = 0, reset = 1, start = 0, cin = 0, sb = 0;
   logic [7:0]  a = 0, b = 0, out;
   logic        cout, busy, done;
   logic        start32 = 0;
   logic [31:0] a32 = 0, b32 = 0, out32;
   logic        cout32, busy32, done32;
`ifdef ADD_SERIAL_FLAGS_EN
   logic        ovf, zero, ovf32, zero32;
`endif
   int checks = 0, errors = 0, lat, seen;
   always #5 clk = ~clk;
   add_serial_nbit #(.WIDTH(8), .DIGIT(2)) u8 (
      .clk(clk), .reset(reset), .start(start), .A(a), .B(b), .cIn(cin), .sub(sb),
      .out(out), .cOut(cout), .busy(busy), .done(done)
`ifdef ADD_SERIAL_FLAGS_EN
      , .ovf(ovf), .zero(zero)
`endif
   );
   add_serial_nbit #(.WIDTH(32), .DIGIT(32)) u32 (
      .clk(clk), .reset(reset), .start(start32), .A(a32), .B(b32), .cIn(cin), .sub(sb),
      .out(out32), .cOut(cout32), .busy(busy32), .done(done32)
`ifdef ADD_SERIAL_FLAGS_EN
      , .ovf(ovf32), .zero(zero32)
`endif
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask
   task automatic wait_done(output int l);
      l = 0;
      while (!done && l < 20) begin
         @(negedge clk);
         l++;
      end
   endtask
   task automatic op(input logic [7:0] x, input logic [7:0] y, input logic ci, input logic s);
      @(negedge clk);
      a = x; b = y; cin = ci; sb = s; start = 1;
      @(negedge clk);
      start = 0;
      check("busy", busy, 1);
      wait_done(lat);
      check("lat", lat, 4);
   endtask
   initial begin
      reset = 1;
      repeat (3) @(negedge clk);
      check("rst_out", out, 0);
      check("rst_cout", cout, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      reset = 0;
      @(negedge clk);
      check("idle_busy", busy, 0);
      op(8'hFF, 8'h01, 0, 0);
      check("t1_out", out, 8'h00);
      check("t1_cout", cout, 1);
`ifdef ADD_SERIAL_FLAGS_EN
      check("t1_zero", zero, 1);
`endif
      @(negedge clk);
      check("t1_pulse", done, 0);
      check("t1_busy", busy, 0);
      op(8'h05, 8'h07, 0, 1);
      check("t2_out", out, 8'hFE);
      check("t2_cout", cout, 0);
`ifdef ADD_SERIAL_FLAGS_EN
      check("t2_ovf", ovf, 0);
`endif
      op(8'h05, 8'h07, 1, 1);
      check("t2b_out", out, 8'hFD);
      check("t2b_cout", cout, 0);
      op(8'h7F, 8'h01, 0, 0);
      check("t3_out", out, 8'h80);
      check("t3_cout", cout, 0);
`ifdef ADD_SERIAL_FLAGS_EN
      check("t3_ovf", ovf, 1);
`endif
      op(8'h80, 8'h01, 0, 1);
      check("t3b_out", out, 8'h7F);
      check("t3b_cout", cout, 1);
`ifdef ADD_SERIAL_FLAGS_EN
      check("t3b_ovf", ovf, 1);
`endif
      op(8'h3C, 8'h0F, 1, 0);
      check("cin_out", out, 8'h4C);
      check("cin_cout", cout, 0);
      op(8'h10, 8'h01, 1, 1);
      check("bin_out", out, 8'h0E);
      check("bin_cout", cout, 1);
      a = 8'h99; b = 8'h99;
      repeat (3) @(negedge clk);
      check("hold_out", out, 8'h0E);
      a = 8'h12; b = 8'h34; cin = 0; sb = 0; start = 1;
      @(negedge clk);
      start = 0;
      @(negedge clk);
      a = 8'hFF; start = 1;
      @(negedge clk);
      start = 0; a = 8'h00;
      wait_done(lat);
      check("t4_lat", lat, 2);
      check("t4_out", out, 8'h46);
      @(negedge clk);
      a = 8'h01; b = 8'h02; start = 1;
      @(negedge clk);
      check("t4b_busy", busy, 1);
      wait_done(lat);
      check("t4b_lat", lat, 4);
      check("t4b_out", out, 8'h03);
      a = 8'h03; b = 8'h04;
      @(negedge clk);
      start = 0;
      check("t4c_busy", busy, 1);
      check("t4c_done", done, 0);
      wait_done(lat);
      check("t4c_lat", lat, 4);
      check("t4c_out", out, 8'h07);
      @(negedge clk);
      a = 8'hAA; b = 8'h55; start = 1;
      @(negedge clk);
      start = 0;
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0;
      check("t5_done", done, 0);
      check("t5_busy", busy, 0);
      check("t5_out", out, 8'h00);
      check("t5_cout", cout, 0);
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         seen |= int'(done);
      end
      check("t5_nodone", seen, 0);
      op(8'hAA, 8'h55, 0, 0);
      check("t5b_out", out, 8'hFF);
      check("t5b_cout", cout, 0);
      @(negedge clk);
      a32 = 32'hFFFFFFFF; b32 = 32'h1; cin = 0; sb = 0; start32 = 1;
      @(negedge clk);
      start32 = 0;
      check("t6_busy", busy32, 1);
      lat = 0;
      while (!done32 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("t6_lat", lat, 1);
      check("t6_out", out32, 32'h0);
      check("t6_cout", cout32, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
